chip8_loadable_memory: RTL and testbench
========================================

CHIP8_LOADABLE_MEMORY -- requirements
Module: chip8_loadable_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter PROG_BASE, default 12'h200, meaning the first program address and the start of the clear/load region.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. Synchronous, active-high reset.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports a_en (in, 1), a_write (in, 1), a_addr (in, ADDR_W), a_in (in, DATA_W) and a_out (out, DATA_W): the CPU read/write port.
REQ-007 SHALL have port a_busy, output, 1 bit: high while the loader owns port A.
REQ-008 SHALL have ports b_addr (in, ADDR_W) and b_out (out, DATA_W): the read-only display/fetch port.
REQ-009 SHALL have ports ld_start (in, 1), ld_valid (in, 1), ld_data (in, DATA_W), ld_last (in, 1) and ld_ready (out, 1): the program loader stream.
REQ-010 SHALL have ports ld_done (out, 1) and ld_err (out, 1): a one-cycle completion pulse and a sticky overflow flag.

Function
REQ-011 SHALL give port A a read latency of 1 cycle; a_out updates only on cycles where a_en=1 and a_busy=0.
REQ-012 SHALL make port A writes write-first: a_out shows a_in on the cycle after the write.
REQ-013 SHALL read port B every cycle with 1-cycle latency; if A writes the same address in the same cycle, b_out SHALL return the old data.
REQ-014 SHALL implement a loader FSM with states IDLE, CLEAR, LOAD and DONE.
REQ-015 IDLE: ld_start=1 SHALL go to CLEAR, set the pointer to PROG_BASE and clear ld_err.
REQ-016 CLEAR: SHALL write 0 to the pointer address each cycle and increment the pointer. At DEPTH-1 it SHALL write, then go to LOAD with the pointer reset to PROG_BASE. This takes DEPTH-PROG_BASE cycles.
REQ-017 LOAD: ld_ready SHALL be 1; each ld_valid&&ld_ready cycle SHALL write ld_data to the pointer and increment the pointer.
REQ-018 LOAD: a handshake with ld_last=1 SHALL go to DONE.
REQ-019 LOAD: a handshake at pointer DEPTH-1 with ld_last=0 SHALL write the byte, set ld_err and go to DONE; the pointer SHALL NOT wrap.
REQ-020 DONE: ld_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 a_busy SHALL be 1 in CLEAR, LOAD and DONE. While a_busy=1, port A accesses SHALL be dropped (no write) and a_out SHALL hold.
REQ-022 ld_start SHALL be ignored outside IDLE.
REQ-023 ld_ready SHALL be 0 outside LOAD; ld_valid outside LOAD SHALL be ignored.
REQ-024 ld_last with ld_valid=0 SHALL have no effect.

Reset
REQ-025 reset SHALL force state IDLE, pointer=PROG_BASE, and a_out, b_out, a_busy, ld_ready, ld_done and ld_err all to 0.
REQ-026 reset SHALL NOT alter memory contents.
REQ-027 reset mid-CLEAR or mid-LOAD SHALL abandon the operation; addresses already written keep their new values.

Configuration
REQ-028 With macro CHIP8_MEM_FONT_EN defined, addresses 0x000-0x04F SHALL initialise to the 80-byte hex font (digits 0-F, 5 bytes each, digit 0 = F0 90 90 90 F0).
REQ-029 Without CHIP8_MEM_FONT_EN, all addresses SHALL initialise to 0.
REQ-030 The loader SHALL never write below PROG_BASE in either configuration.

Structure
REQ-031 Package chip8_mem_pkg SHALL hold the loader state enum, the FONT constant array and the PROG_BASE default.
REQ-032 Sub-module chip8_dpram SHALL be the inferred single-clock true dual-port RAM (A: read/write, write-first; B: read-only); the top level SHALL hold the FSM and port-A muxing.

Verification
REQ-033 Font check (macro on, reset released): b_addr=0x000..0x004 -> b_out=F0,90,90,90,F0 one cycle later. With the macro off -> all 00.
REQ-034 Port A write/read: write 0xA5 to 0x300, then read 0x300 -> a_out=A5 after 1 cycle. A same-cycle B read of 0x300 -> old value, then A5 on the next read.
REQ-035 Load: ld_start, then after 3584 CLEAR cycles stream 12 34 56 (last on 56) -> 0x200..0x202 = 12 34 56, 0x203 = 00, ld_done pulses once, ld_err=0, a_busy falls.
REQ-036 Overflow: stream 3585 bytes with no ld_last -> 0xFFF holds byte 3584, ld_err=1, ld_done pulses, byte 3585 never accepted.
REQ-037 Busy lockout: a_en=1 a_write=1 to 0x210 during CLEAR -> 0x210 reads 00 after the load; ld_start during LOAD is ignored.
REQ-038 Mid-load reset: reset after 2 LOAD bytes -> FSM IDLE, outputs 0, first 2 bytes retained, the rest of the region stays 00.

Source files
------------

// File: rtl/chip8_mem_pkg.sv
// Shared types and constants for the CHIP-8 loadable memory.
// Holds the loader state enum, the hex font table and the program base.
package chip8_mem_pkg;

  localparam logic [11:0] PROG_BASE_DEFAULT = 12'h200;
  localparam int          FONT_BYTES        = 80;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_CLEAR,
    LD_LOAD,
    LD_DONE
  } ld_state_e;

  // Digits 0-F, five rows each, MSB-aligned 4-pixel glyphs.
  localparam logic [7:0] FONT [FONT_BYTES] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

endpackage

// File: rtl/chip8_loadable_memory_dpram.sv
// Single-clock true dual-port RAM: A read/write (write-first), B read-only.
// Ports: clk, reset (clears only the output registers), a_en/a_we/a_addr/
// a_wdata/a_rdata, b_addr/b_rdata. a_en gates the A output register only.
module chip8_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  always_comb begin
    a_rdata_d = a_rdata_q;
    if (a_en) begin
      a_rdata_d = a_we ? a_wdata : mem_q[a_addr];
    end
    // B sees the array before this cycle's A write lands.
    b_rdata_d = mem_q[b_addr];
  end

  // Array contents are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem_q[a_addr] <= a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/chip8_loadable_memory.sv
// CHIP-8 4K memory with a CPU port (A), a fetch/display port (B) and a
// streaming program loader that clears then fills PROG_BASE..DEPTH-1.
// Ports: clk, reset (sync, active high); a_en/a_write/a_addr/a_in/a_out,
// a_busy; b_addr/b_out; ld_start/ld_valid/ld_data/ld_last/ld_ready,
// ld_done (1-cycle pulse), ld_err (sticky overflow).
// Build option CHIP8_MEM_FONT_EN: 0x000-0x04F power up holding the hex font
// (served from a ROM overlay until the CPU overwrites a byte).
module chip8_loadable_memory
  import chip8_mem_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] PROG_BASE = ADDR_W'(PROG_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_en,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_busy,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_out,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err
);

  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              ld_we;
  logic [DATA_W-1:0] ld_wdata;

  logic              ram_we;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_a_rdata;
  logic [DATA_W-1:0] ram_b_rdata;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    err_d    = err_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    ld_we    = 1'b0;
    ld_wdata = '0;
    unique case (state_q)
      LD_IDLE: begin
        if (ld_start) begin
          state_d = LD_CLEAR;
          ptr_d   = PROG_BASE;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      LD_CLEAR: begin
        ld_we = 1'b1;
        if (ptr_q == LAST) begin
          state_d = LD_LOAD;
          ptr_d   = PROG_BASE;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      LD_LOAD: begin
        if (ld_valid) begin
          ld_we    = 1'b1;
          ld_wdata = ld_data;
          // The pointer parks at the top instead of wrapping.
          if (ptr_q != LAST) begin
            ptr_d = ptr_q + 1'b1;
          end
          if (ld_last || ptr_q == LAST) begin
            state_d = LD_DONE;
            ready_d = 1'b0;
            done_d  = 1'b1;
            err_d   = !ld_last;
          end
        end
      end
      LD_DONE: begin
        state_d = LD_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_IDLE;
      ptr_q   <= PROG_BASE;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  // Loader owns port A while busy; no write lands during a reset cycle.
  assign ram_we    = !reset && (busy_q ? ld_we : (a_en && a_write));
  assign ram_rd_en = !busy_q && a_en;
  assign ram_addr  = busy_q ? ptr_q : a_addr;
  assign ram_wdata = busy_q ? ld_wdata : a_in;

  chip8_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .a_en    (ram_rd_en),
    .a_we    (ram_we),
    .a_addr  (ram_addr),
    .a_wdata (ram_wdata),
    .a_rdata (ram_a_rdata),
    .b_addr  (b_addr),
    .b_rdata (ram_b_rdata)
  );

`ifdef CHIP8_MEM_FONT_EN
  // Font bytes come from ROM until a write marks that byte dirty; the
  // dirty bits are power-up state like the array and ignore reset.
  localparam logic [ADDR_W-1:0] FONT_END = ADDR_W'(FONT_BYTES);

  logic [FONT_BYTES-1:0] dirty_q, dirty_d;
  logic                  a_font_q, a_font_d;
  logic                  b_font_q, b_font_d;
  logic [DATA_W-1:0]     a_fbyte_q, a_fbyte_d;
  logic [DATA_W-1:0]     b_fbyte_q, b_fbyte_d;
  logic [6:0]            w_idx, a_idx, b_idx;
  logic                  w_in, a_in_font, b_in_font;

  always_comb begin
    w_in      = ram_addr < FONT_END;
    a_in_font = a_addr < FONT_END;
    b_in_font = b_addr < FONT_END;
    w_idx     = w_in ? ram_addr[6:0] : 7'd0;
    a_idx     = a_in_font ? a_addr[6:0] : 7'd0;
    b_idx     = b_in_font ? b_addr[6:0] : 7'd0;

    dirty_d = dirty_q;
    if (ram_we && w_in) begin
      dirty_d[w_idx] = 1'b1;
    end

    a_font_d  = a_font_q;
    a_fbyte_d = a_fbyte_q;
    if (ram_rd_en) begin
      a_font_d  = a_in_font && !a_write && !dirty_q[a_idx];
      a_fbyte_d = DATA_W'(FONT[a_idx]);
    end

    b_font_d  = b_in_font && !dirty_q[b_idx];
    b_fbyte_d = DATA_W'(FONT[b_idx]);
  end

  always_ff @(posedge clk) begin
    dirty_q <= dirty_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_font_q  <= 1'b0;
      b_font_q  <= 1'b0;
      a_fbyte_q <= '0;
      b_fbyte_q <= '0;
    end else begin
      a_font_q  <= a_font_d;
      b_font_q  <= b_font_d;
      a_fbyte_q <= a_fbyte_d;
      b_fbyte_q <= b_fbyte_d;
    end
  end

  assign a_out = a_font_q ? a_fbyte_q : ram_a_rdata;
  assign b_out = b_font_q ? b_fbyte_q : ram_b_rdata;
`else
  assign a_out = ram_a_rdata;
  assign b_out = ram_b_rdata;
`endif

  assign a_busy   = busy_q;
  assign ld_ready = ready_q;
  assign ld_done  = done_q;
  assign ld_err   = err_q;

endmodule

// File: tb/tb_chip8_loadable_memory.sv
// Directed bench for chip8_loadable_memory: reset, ports A/B, load,
// overflow, busy lockout and mid-load reset, with a read scoreboard.
module tb_chip8_loadable_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_en = 1'b0;
  logic        a_write = 1'b0;
  logic [11:0] a_addr = '0;
  logic [7:0]  a_in = '0;
  logic [7:0]  a_out;
  logic        a_busy;
  logic [11:0] b_addr = '0;
  logic [7:0]  b_out;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        ld_done;
  logic        ld_err;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q [$];
  logic [7:0] font0 [5] = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};

  chip8_loadable_memory dut (
    .clk      (clk),
    .reset    (reset),
    .a_en     (a_en),
    .a_write  (a_write),
    .a_addr   (a_addr),
    .a_in     (a_in),
    .a_out    (a_out),
    .a_busy   (a_busy),
    .b_addr   (b_addr),
    .b_out    (b_out),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_err   (ld_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_b(input logic [11:0] addr, input logic [7:0] exp);
    b_addr = addr;
    sb_q.push_back(exp);
    step();
    chk($sformatf("b_rd_%03h", addr), 32'(b_out), 32'(sb_q.pop_front()));
  endtask

  task automatic read_a(input logic [11:0] addr, input logic [7:0] exp);
    a_en = 1'b1;
    a_write = 1'b0;
    a_addr = addr;
    sb_q.push_back(exp);
    step();
    a_en = 1'b0;
    chk($sformatf("a_rd_%03h", addr), 32'(a_out), 32'(sb_q.pop_front()));
  endtask

  task automatic start_load(input string tag);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk({tag, "_busy"}, 32'(a_busy), 32'd1);
    chk({tag, "_err_clr"}, 32'(ld_err), 32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ld_ready && n < 5000) begin
      step();
      n++;
    end
    chk({tag, "_clear_cycles"}, 32'(n), 32'd3584);
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk_idle_outs(input string tag, input logic err_exp);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_ready"}, 32'(ld_ready), 32'd0);
    chk({tag, "_done"}, 32'(ld_done), 32'd0);
    chk({tag, "_err"}, 32'(ld_err), 32'(err_exp));
  endtask

  initial begin
    repeat (3) step();
    chk_idle_outs("rst", 1'b0);
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    reset = 1'b0;
    step();

    // Power-up contents of the font area.
    for (int i = 0; i < 5; i++) begin
`ifdef CHIP8_MEM_FONT_EN
      read_b(12'(i), font0[i]);
`else
      read_b(12'(i), 8'h00);
`endif
    end

    // Write-first on A, old data on B for a same-cycle collision.
    a_en = 1'b1;
    a_write = 1'b1;
    a_addr = 12'h300;
    a_in = 8'hA5;
    b_addr = 12'h300;
    sb_q.push_back(8'h00);
    step();
    chk("wr_first_a", 32'(a_out), 32'hA5);
    chk("collide_b_old", 32'(b_out), 32'(sb_q.pop_front()));
    a_write = 1'b0;
    sb_q.push_back(8'hA5);
    step();
    chk("rd_a_300", 32'(a_out), 32'hA5);
    chk("rd_b_300_new", 32'(b_out), 32'(sb_q.pop_front()));
    a_write = 1'b1;
    a_addr = 12'h1FF;
    a_in = 8'h5A;
    step();
    a_en = 1'b0;
    a_write = 1'b0;
    a_addr = 12'h300;
    step();
    chk("a_hold_no_en", 32'(a_out), 32'h5A);

    // Normal load, with a CPU write held on 0x210 all through CLEAR.
    start_load("ld1");
    a_en = 1'b1;
    a_write = 1'b1;
    a_addr = 12'h210;
    a_in = 8'h77;
    wait_ready("ld1");
    a_en = 1'b0;
    a_write = 1'b0;
    chk("busy_a_hold", 32'(a_out), 32'h5A);
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    chk("start_in_load", 32'(ld_ready), 32'd1);
    ld_last = 1'b1;
    step();
    ld_last = 1'b0;
    chk("last_no_valid", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1;
    ld_data = 8'h12;
    step();
    ld_data = 8'h34;
    step();
    ld_data = 8'h56;
    ld_last = 1'b1;
    step();
    ld_valid = 1'b0;
    ld_last = 1'b0;
    chk("ld1_done", 32'(ld_done), 32'd1);
    chk("ld1_done_busy", 32'(a_busy), 32'd1);
    chk("ld1_done_ready", 32'(ld_ready), 32'd0);
    step();
    chk_idle_outs("ld1_after", 1'b0);
    read_b(12'h200, 8'h12);
    read_b(12'h201, 8'h34);
    read_b(12'h202, 8'h56);
    read_b(12'h203, 8'h00);
    read_b(12'h210, 8'h00);
    read_b(12'h300, 8'h00);
    read_b(12'h1FF, 8'h5A);
    read_a(12'h201, 8'h34);

    // Overflow: 3584 bytes fill the region, the next one is refused.
    start_load("ovf");
    wait_ready("ovf");
    ld_valid = 1'b1;
    for (int i = 1; i <= 3584; i++) begin
      ld_data = pat(i);
      step();
    end
    chk("ovf_done", 32'(ld_done), 32'd1);
    chk("ovf_err", 32'(ld_err), 32'd1);
    chk("ovf_ready", 32'(ld_ready), 32'd0);
    ld_data = 8'hEE;
    step();
    chk_idle_outs("ovf_after", 1'b1);
    step();
    ld_valid = 1'b0;
    chk("ovf_err_sticky", 32'(ld_err), 32'd1);
    read_b(12'h200, pat(1));
    read_b(12'h201, pat(2));
    read_b(12'hFFE, pat(3583));
    read_b(12'hFFF, pat(3584));
    read_b(12'h1FF, 8'h5A);

    // Reset part-way through LOAD.
    start_load("mid");
    wait_ready("mid");
    ld_valid = 1'b1;
    ld_data = 8'hAB;
    step();
    ld_data = 8'hCD;
    step();
    ld_valid = 1'b0;
    reset = 1'b1;
    step();
    chk_idle_outs("mid_rst", 1'b0);
    chk("mid_rst_a_out", 32'(a_out), 32'd0);
    chk("mid_rst_b_out", 32'(b_out), 32'd0);
    reset = 1'b0;
    step();
    chk_idle_outs("mid_after", 1'b0);
    read_b(12'h200, 8'hAB);
    read_b(12'h201, 8'hCD);
    read_b(12'h202, 8'h00);
    read_b(12'hFFF, 8'h00);
    read_b(12'h1FF, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
